bus_cycle_controller: RTL

Sequences every 68000 bus cycle on the mackerel-10 system controller CPLD. It replaces the tied-off DTACK/BERR/VPA/IACK_DUART signals with a cycle-aware controller. Per address region it inserts a programmable number of wait states, then terminates the cycle with DTACK. It services interrupt-acknowledge cycles with either a DUART vectored acknowledge or a VPA autovector, and optionally bus-errors cycles that nothing answers. It runs in the CPU clock domain, beside the chip-select decode.

---
 rtl/bus_cycle_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bus_cycle_controller.sv
// 68000 bus-cycle sequencer: per-region wait states, DTACK/VPA termination, DUART IACK.
// Define BERR_WATCHDOG_EN to bus-error cycles that stay unanswered (watchdog + BERR).
module bus_cycle_controller #(
    parameter int unsigned ROM_WS       = 2,
    parameter int unsigned RAM_WS       = 0,
    parameter int unsigned DUART_WS     = 3,
    parameter int unsigned EXP_WS       = 4,
    parameter int unsigned DUART_IPL    = 5,
    parameter int unsigned BERR_TIMEOUT = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       UDS,
    input  logic       LDS,
    input  logic [2:0] FC,
    input  logic [9:0] ADDR_H,
    input  logic [3:0] ADDR_L,
    output logic       DTACK,
    output logic       VPA,
    output logic       BERR,
    output logic       IACK_DUART
);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2, S_BERR = 2'd3;

    localparam logic [2:0] C_ROM = 3'd0, C_RAM = 3'd1, C_DUART = 3'd2, C_EXP = 3'd3,
                           C_IO = 3'd4, C_UNMAP = 3'd5, C_DIACK = 3'd6, C_AUTOVEC = 3'd7;
`ifdef BERR_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic [1:0] state_q, state_d;
    logic [2:0] cls_q, cls_d, cls;
    logic [7:0] cnt_q, cnt_d, ws;
    logic       armed_q, armed_d;
    logic       dtack_q, dtack_d, vpa_q, vpa_d, berr_q, berr_d, iack_q, iack_d;
    logic       is_iack, hang, wd_hit;

    // Strobes and low address bits carry no sequencing information.
    logic unused_ok;
    assign unused_ok = &{1'b0, UDS, LDS, ADDR_H[1:0], ADDR_L[3]};

    assign is_iack = (FC == 3'b111) && (ADDR_H[5:2] == 4'hF);

    always_comb begin
        cls = C_UNMAP;
        ws  = 8'd0;
        if (is_iack) begin
            if (ADDR_L[2:0] == 3'(DUART_IPL)) begin
                cls = C_DIACK;
                ws  = 8'(DUART_WS);
            end else begin
                cls = C_AUTOVEC;
            end
        end else begin
            case (ADDR_H[9:6])
                4'h0:       begin cls = C_ROM;   ws = 8'(ROM_WS);   end
                4'h8:       begin cls = C_RAM;   ws = 8'(RAM_WS);   end
                4'hC:       begin cls = C_DUART; ws = 8'(DUART_WS); end
                4'hD, 4'hE: begin cls = C_EXP;   ws = 8'(EXP_WS);   end
                4'hF:       cls = C_IO;
                default:    cls = C_UNMAP;
            endcase
        end
    end

    // Unmapped cycles only end through the watchdog when it exists.
    assign hang = WD_EN && (cls_q == C_UNMAP);

`ifdef BERR_WATCHDOG_EN
    logic [7:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == S_IDLE) wd_d = 8'd0;
        else if (!AS)          wd_d = wd_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) wd_q <= 8'd0;
        else      wd_q <= wd_d;
    end

    assign wd_hit = (state_q == S_WAIT) && !AS && (wd_q == 8'(BERR_TIMEOUT - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        armed_d = armed_q | AS;
        dtack_d = dtack_q;
        vpa_d   = vpa_q;
        berr_d  = berr_q;
        iack_d  = iack_q;
        if (state_q != S_IDLE && AS) begin
            // AS negated: end (or abort) the cycle and release every output.
            state_d = S_IDLE;
            dtack_d = 1'b1;
            vpa_d   = 1'b1;
            berr_d  = 1'b1;
            iack_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!AS && armed_q) begin
                        cls_d   = cls;
                        cnt_d   = ws;
                        iack_d  = (cls != C_DIACK);
                        state_d = (ws != 8'd0 || (WD_EN && cls == C_UNMAP)) ? S_WAIT : S_ACK;
                    end
                end
                S_WAIT: begin
                    if (wd_hit) begin
                        state_d = S_BERR;
                        berr_d  = 1'b0;
                    end else if (!hang) begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_d = S_ACK;
                    end
                end
                S_ACK: begin
                    if (cls_q == C_AUTOVEC) vpa_d = 1'b0;
                    else                    dtack_d = 1'b0;
                end
                default: berr_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cls_q   <= C_ROM;
            cnt_q   <= 8'd0;
            armed_q <= 1'b0;
            dtack_q <= 1'b1;
            vpa_q   <= 1'b1;
            berr_q  <= 1'b1;
            iack_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            dtack_q <= dtack_d;
            vpa_q   <= vpa_d;
            berr_q  <= berr_d;
            iack_q  <= iack_d;
        end
    end

    assign DTACK      = dtack_q;
    assign VPA        = vpa_q;
    assign BERR       = berr_q;
    assign IACK_DUART = iack_q;
endmodule
